// File: rtl/aes_sbox_pkg.sv
// Shared AES S-box definitions: affine constants and transforms, GF(2^8) helpers,
// the 128-bit state type and the iterative engine's FSM encoding.
package aes_sbox_pkg;

  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sb_fsm_e;

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // FIPS-197 affine matrix without the additive constant
  function automatic logic [7:0] affine_fwd(logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4);
  endfunction

  function automatic logic [7:0] affine_inv(logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6);
  endfunction

  function automatic logic [7:0] gf_xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // Counter width for the byte-group index; never narrower than one bit
  function automatic int cnt_width(int lanes);
    return (lanes >= 16) ? 1 : $clog2(16 / lanes);
  endfunction

endpackage

// File: rtl/subbytes_iter_if.sv
// Block-level handshake bundle of the iterative SubBytes engine.
// valid/ready: a transfer happens on a rising edge where valid && ready; the sender
// holds valid and payload stable until that edge, and valid never waits on ready.
interface subbytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/GF_MULINV_8_ny.sv
// Combinational GF(2^8) multiplicative inverse over x^8+x^4+x^3+x+1, inv(0)=0.
// Computed as x^254 = x^2 * x^4 * ... * x^128 so zero maps to zero for free.
module GF_MULINV_8_ny
  import aes_sbox_pkg::*;
(
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);

  logic [7:0] w_p2, w_p4, w_p8, w_p16, w_p32, w_p64, w_p128;
  logic [7:0] w_m6, w_m14, w_m30, w_m62, w_m126;

  assign w_p2   = gf_mul(i_x, i_x);
  assign w_p4   = gf_mul(w_p2, w_p2);
  assign w_p8   = gf_mul(w_p4, w_p4);
  assign w_p16  = gf_mul(w_p8, w_p8);
  assign w_p32  = gf_mul(w_p16, w_p16);
  assign w_p64  = gf_mul(w_p32, w_p32);
  assign w_p128 = gf_mul(w_p64, w_p64);

  assign w_m6   = gf_mul(w_p2, w_p4);
  assign w_m14  = gf_mul(w_m6, w_p8);
  assign w_m30  = gf_mul(w_m14, w_p16);
  assign w_m62  = gf_mul(w_m30, w_p32);
  assign w_m126 = gf_mul(w_m62, w_p64);
  assign o_y    = gf_mul(w_m126, w_p128);

endmodule

// File: rtl/sbox_lane_fi.sv
// One forward/inverse S-box lane: a single shared inverter, with the mode bit
// choosing whether the affine stage sits before (inverse) or after (forward) it.
module sbox_lane_fi
  import aes_sbox_pkg::*;
#(
  parameter int ENABLE_DEC = 1
) (
  input  logic [7:0] i_byte,
  input  logic       i_mode,
  output logic [7:0] o_byte
);

  logic       w_dec;
  logic [7:0] w_pre;
  logic [7:0] w_inv_in;
  logic [7:0] w_inv_out;
  logic [7:0] w_post;

  assign w_dec    = (ENABLE_DEC != 0) && i_mode;
  assign w_pre    = affine_inv(i_byte) ^ INV_AFFINE_C;
  assign w_inv_in = w_dec ? w_pre : i_byte;

  GF_MULINV_8_ny u_inv (
    .i_x (w_inv_in),
    .o_y (w_inv_out)
  );

  assign w_post = affine_fwd(w_inv_out) ^ AFFINE_C;
  assign o_byte = w_dec ? w_inv_out : w_post;

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes over the full 128-bit state, LANES bytes per cycle,
// with an optional register between the S-box lanes and the state write-back.
module subbytes_iter
  import aes_sbox_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int PIPE       = 0,
  parameter int ENABLE_DEC = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  subbytes_iter_if.slave                bus,
  output sb_fsm_e                       o_dbg_state,
  output logic [cnt_width(LANES)-1:0]   o_dbg_cnt
);

  localparam int NGRP  = 16 / LANES;
  localparam int CNT_W = cnt_width(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NGRP - 1);

  sb_fsm_e          r_fsm;
  sb_fsm_e          w_fsm_nxt;
  aes_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;

  logic             w_accept;
  logic             w_release;
  logic             w_issue;
  logic             w_wr_en;
  logic             w_wr_last;
  logic [CNT_W-1:0] w_wr_grp;
  logic [7:0]       w_lane_in  [LANES];
  logic [7:0]       w_lane_out [LANES];
  logic [7:0]       w_wr_data  [LANES];

  function automatic logic [3:0] byte_idx(logic [CNT_W-1:0] g, int l);
    return 4'(g) * 4'(LANES) + 4'(l);
  endfunction

  assign bus.in_ready  = (r_fsm == ST_IDLE) || ((r_fsm == ST_DONE) && bus.out_ready);
  assign bus.out_valid = (r_fsm == ST_DONE);
  assign bus.out_data  = (r_fsm == ST_DONE) ? r_state : '0;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_release = bus.out_valid && bus.out_ready;
  assign w_wr_last = w_wr_en && (w_wr_grp == LAST);

  assign o_dbg_state = r_fsm;
  assign o_dbg_cnt   = r_cnt;

  // Group mux feeding the shared lanes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_in[l] = r_state[byte_idx(r_cnt, l)];

    sbox_lane_fi #(
      .ENABLE_DEC (ENABLE_DEC)
    ) u_lane (
      .i_byte (w_lane_in[l]),
      .i_mode (r_mode),
      .o_byte (w_lane_out[l])
    );
  end

  // With PIPE, issue of group g overlaps write-back of group g-1
  if (PIPE != 0) begin : g_pipe
    logic [7:0]       r_pipe_data [LANES];
    logic [CNT_W-1:0] r_pipe_grp;
    logic             r_pipe_vld;
    logic             r_issued_all;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pipe_vld   <= 1'b0;
        r_pipe_grp   <= '0;
        r_issued_all <= 1'b0;
        for (int l = 0; l < LANES; l++) r_pipe_data[l] <= '0;
      end else begin
        r_pipe_vld <= w_issue;
        if (w_issue) begin
          r_pipe_grp  <= r_cnt;
          r_pipe_data <= w_lane_out;
        end
        if (w_accept) r_issued_all <= 1'b0;
        else if (w_issue && (r_cnt == LAST)) r_issued_all <= 1'b1;
      end
    end

    assign w_issue   = (r_fsm == ST_RUN) && !r_issued_all;
    assign w_wr_en   = r_pipe_vld;
    assign w_wr_grp  = r_pipe_grp;
    assign w_wr_data = r_pipe_data;
  end else begin : g_direct
    assign w_issue   = (r_fsm == ST_RUN);
    assign w_wr_en   = w_issue;
    assign w_wr_grp  = r_cnt;
    assign w_wr_data = w_lane_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      ST_IDLE: if (w_accept) w_fsm_nxt = ST_RUN;
      ST_RUN:  if (w_wr_last) w_fsm_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept)       w_fsm_nxt = ST_RUN;
        else if (w_release) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else if (w_accept) begin
      r_state <= bus.in_data;
      r_mode  <= (ENABLE_DEC != 0) && bus.in_mode;
      r_cnt   <= '0;
    end else begin
      if (w_issue && (r_cnt != LAST)) r_cnt <= r_cnt + 1'b1;
      if (w_wr_en) begin
        for (int l = 0; l < LANES; l++) r_state[byte_idx(w_wr_grp, l)] <= w_wr_data[l];
      end
    end
  end

endmodule
